// File: rtl/nebula_pkg.sv
// Shared types and widths for the nebula NoC local network interface.
// The flit layout, flit kinds and NIU state encodings live here.
package nebula_pkg;

  localparam int COORD_WIDTH       = 4;
  localparam int PAYLOAD_WIDTH     = 32;
  localparam int NIU_MAX_PKT_FLITS = 8;
  localparam int LEN_WIDTH         = $clog2(NIU_MAX_PKT_FLITS + 1);

  typedef enum logic [1:0] {
    FLIT_IDLE = 2'd0,
    FLIT_HEAD = 2'd1,
    FLIT_BODY = 2'd2,
    FLIT_TAIL = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e               ftype;
    logic [COORD_WIDTH-1:0]   dest_x;
    logic [COORD_WIDTH-1:0]   dest_y;
    logic [COORD_WIDTH-1:0]   src_x;
    logic [COORD_WIDTH-1:0]   src_y;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } noc_flit_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_DATA = 2'd2
  } niu_tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_PKT  = 1'b1
  } niu_rx_state_e;

  function automatic noc_flit_t make_flit(
    input flit_type_e               ftype,
    input logic [COORD_WIDTH-1:0]   dest_x,
    input logic [COORD_WIDTH-1:0]   dest_y,
    input logic [COORD_WIDTH-1:0]   src_x,
    input logic [COORD_WIDTH-1:0]   src_y,
    input logic [PAYLOAD_WIDTH-1:0] payload
  );
    noc_flit_t f;
    f.ftype   = ftype;
    f.dest_x  = dest_x;
    f.dest_y  = dest_y;
    f.src_x   = src_x;
    f.src_y   = src_y;
    f.payload = payload;
    return f;
  endfunction

endpackage

// File: rtl/nebula_sync_fifo.sv
// Single-clock FIFO with full/empty flags; pushes when full and pops when
// empty are ignored. Storage is not reset, only the pointers are.
module nebula_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nebula_local_niu.sv
// Local-port network interface: packetises core requests into HEAD/BODY/TAIL
// flits and de-packetises ejected flits into a payload FIFO for the core.
module nebula_local_niu
  import nebula_pkg::*;
#(
  parameter int NODE_X        = 0,
  parameter int NODE_Y        = 0,
  parameter int MAX_PKT_FLITS = NIU_MAX_PKT_FLITS,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [COORD_WIDTH-1:0]   req_dest_x,
  input  logic [COORD_WIDTH-1:0]   req_dest_y,
  input  logic [LEN_WIDTH-1:0]     req_len,
  input  logic                     pl_valid,
  output logic                     pl_ready,
  input  logic [PAYLOAD_WIDTH-1:0] pl_data,
  output logic                     flit_out_valid,
  output noc_flit_t                flit_out,
  input  logic                     flit_out_ready,
  input  logic                     flit_in_valid,
  input  noc_flit_t                flit_in,
  output logic                     flit_in_ready,
  output logic                     rx_valid,
  output logic [PAYLOAD_WIDTH-1:0] rx_data,
  output logic                     rx_last,
  output logic [COORD_WIDTH-1:0]   rx_src_x,
  output logic [COORD_WIDTH-1:0]   rx_src_y,
  input  logic                     rx_ready,
  output logic [31:0]              pkts_sent,
  output logic [31:0]              pkts_received,
  output logic                     err_len,
  output logic                     err_proto
);

  localparam logic [COORD_WIDTH-1:0] SRC_X = COORD_WIDTH'(NODE_X);
  localparam logic [COORD_WIDTH-1:0] SRC_Y = COORD_WIDTH'(NODE_Y);

  niu_tx_state_e tx_state, tx_next;
  niu_rx_state_e rx_state, rx_next;

  // ---------------- injection ----------------
  logic [COORD_WIDTH-1:0] dest_x_q, dest_y_q;
  logic [LEN_WIDTH-1:0]   len_q, remaining;
  noc_flit_t              flit_q;
  logic                   flit_v_q;
  logic                   req_legal;
  logic                   out_free;
  logic                   pl_fire;
  logic                   tail_done;

  assign req_legal      = (req_len != '0) && (int'(req_len) <= MAX_PKT_FLITS);
  assign out_free       = !flit_v_q || flit_out_ready;
  assign flit_out       = flit_q;
  assign flit_out_valid = flit_v_q;
  assign pl_fire        = pl_valid && pl_ready;

  always_comb begin
    tx_next   = tx_state;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    tail_done = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && req_legal) tx_next = TX_HEAD;
      end
      TX_HEAD: begin
        if (flit_out_ready) tx_next = TX_DATA;
      end
      TX_DATA: begin
        // Once the TAIL is loaded remaining is zero, so no further words are taken.
        pl_ready = out_free && (remaining != '0);
        if (flit_v_q && flit_out_ready && flit_q.ftype == FLIT_TAIL) begin
          tail_done = 1'b1;
          tx_next   = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dest_x_q  <= '0;
      dest_y_q  <= '0;
      len_q     <= '0;
      remaining <= '0;
      flit_q    <= '0;
      flit_v_q  <= 1'b0;
      err_len   <= 1'b0;
      pkts_sent <= '0;
    end else begin
      err_len <= (tx_state == TX_IDLE) && req_valid && !req_legal;
      case (tx_state)
        TX_IDLE: begin
          if (req_valid && req_legal) begin
            dest_x_q <= req_dest_x;
            dest_y_q <= req_dest_y;
            len_q    <= req_len;
            flit_q   <= make_flit(FLIT_HEAD, req_dest_x, req_dest_y, SRC_X, SRC_Y,
                                  PAYLOAD_WIDTH'(req_len));
            flit_v_q <= 1'b1;
          end
        end
        TX_HEAD: begin
          if (flit_out_ready) begin
            flit_v_q  <= 1'b0;
            remaining <= len_q;
          end
        end
        TX_DATA: begin
          if (pl_fire) begin
            flit_q    <= make_flit((remaining == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY,
                                   dest_x_q, dest_y_q, SRC_X, SRC_Y, pl_data);
            flit_v_q  <= 1'b1;
            remaining <= remaining - LEN_WIDTH'(1);
          end else if (flit_out_ready) begin
            flit_v_q <= 1'b0;
          end
        end
        default: flit_v_q <= 1'b0;
      endcase
      if (tail_done) pkts_sent <= pkts_sent + 32'd1;
    end
  end

  // ---------------- ejection ----------------
  logic                   in_is_head, in_is_data, in_is_tail;
  logic                   pushable, in_fire, fifo_push, fifo_pop;
  logic                   proto_err;
  logic                   fifo_full, fifo_empty;
  logic [PAYLOAD_WIDTH:0] fifo_rdata;

  assign in_is_head = (flit_in.ftype == FLIT_HEAD);
  assign in_is_tail = (flit_in.ftype == FLIT_TAIL);
  assign in_is_data = (flit_in.ftype == FLIT_BODY) || in_is_tail;
  assign pushable   = (rx_state == RX_PKT) && in_is_data;
  // Only flits that land in the FIFO can be blocked; everything else is absorbed.
  assign flit_in_ready = pushable ? !fifo_full : 1'b1;
  assign in_fire    = flit_in_valid && flit_in_ready;
  assign fifo_push  = in_fire && pushable;
  assign proto_err  = in_fire && (((rx_state == RX_IDLE) && in_is_data) ||
                                  ((rx_state == RX_PKT) && in_is_head));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (in_fire && in_is_head) rx_next = RX_PKT;
      RX_PKT:  if (in_fire && in_is_tail) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_src_x      <= '0;
      rx_src_y      <= '0;
      err_proto     <= 1'b0;
      pkts_received <= '0;
    end else begin
      err_proto <= proto_err;
      if (in_fire && in_is_head) begin
        rx_src_x <= flit_in.src_x;
        rx_src_y <= flit_in.src_y;
      end
      if (fifo_push && in_is_tail) pkts_received <= pkts_received + 32'd1;
    end
  end

  nebula_sync_fifo #(
    .WIDTH (PAYLOAD_WIDTH + 1),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({in_is_tail, flit_in.payload}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Storage is unreset, so the outputs are masked while the FIFO is empty.
  assign rx_valid = !fifo_empty;
  assign fifo_pop = rx_valid && rx_ready;
  assign rx_data  = fifo_empty ? '0 : fifo_rdata[PAYLOAD_WIDTH-1:0];
  assign rx_last  = !fifo_empty && fifo_rdata[PAYLOAD_WIDTH];

endmodule
